vend_ctrl_param: RTL and testbench

Parametrised vending-machine controller and successor to state_transitions. It provides a multi-entry cart, N configurable coin denominations, an inactivity timeout, and coin-by-coin greedy change and refund output. It sits between the debounced button/switch/coin-pulse front end and the display driver. Item prices come from an external price table through a combinational lookup port. Seven-segment driving is out of scope; the display consumes need_money, input_money, change_money and state_out.

---
 rtl/vend_ctrl_param.sv | 177 +++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: multi-entry cart, N coin denominations,
// inactivity timeout, and greedy one-coin-per-cycle change/refund dispensing.
module vend_ctrl_param #(
  parameter int unsigned MONEY_W     = 8,
  parameter int unsigned CART_DEPTH  = 4,
  parameter int unsigned NUM_COINS   = 5,
  parameter logic [NUM_COINS*MONEY_W-1:0] COIN_VALUES = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1},
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              sys_Goods,
  input  logic                              sys_Confirm,
  input  logic                              sys_Change,
  input  logic                              sys_Cancel,
  input  logic [NUM_COINS-1:0]              coin_in,
  input  logic [2:0]                        type_SW_high,
  input  logic [2:0]                        type_SW_low,
  input  logic [1:0]                        num_SW,
  output logic [5:0]                        price_addr,
  input  logic [MONEY_W-1:0]                price_data,
  output logic [MONEY_W-1:0]                need_money,
  output logic [MONEY_W-1:0]                input_money,
  output logic [MONEY_W-1:0]                change_money,
  output logic [NUM_COINS-1:0]              coin_out,
  output logic                              coin_reject,
  output logic [$clog2(CART_DEPTH+1)-1:0]   cart_count,
  output logic                              cart_full,
  output logic                              vend_done,
  output logic [5:0]                        state_out
);

  localparam int unsigned CNT_W = $clog2(CART_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned ACC_W = MONEY_W + 3;
  localparam logic [ACC_W-1:0] MONEY_MAX = {3'b000, {MONEY_W{1'b1}}};

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    SELECT = 6'b000010,
    PAY    = 6'b000100,
    CHANGE = 6'b001000,
    REFUND = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t               state, state_nxt;
  logic [MONEY_W-1:0]   need_nxt, input_nxt, change_nxt;
  logic [CNT_W-1:0]     cart_nxt;
  logic [NUM_COINS-1:0] coin_out_nxt;
  logic                 reject_nxt, done_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;

  logic [ACC_W-1:0]     item_cost, need_sum, coin_sum, pay_sum;
  logic [MONEY_W-1:0]   need_add, paid, sel_val;
  logic [NUM_COINS-1:0] sel_onehot;
  logic                 add_ok, activity, tmo_hit;

  assign price_addr = {type_SW_high, type_SW_low};
  assign state_out  = state;

  assign item_cost = ACC_W'(price_data) * ACC_W'(num_SW);
  assign need_sum  = ACC_W'(need_money) + item_cost;
  assign need_add  = (need_sum > MONEY_MAX) ? '1 : need_sum[MONEY_W-1:0];
  assign add_ok    = (num_SW != 2'd0) && (cart_count != CNT_W'(CART_DEPTH));
  assign activity  = sys_Goods | sys_Confirm | sys_Change | sys_Cancel | (|coin_in);
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) && !activity;

  always_comb begin
    coin_sum = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++)
      if (coin_in[i]) coin_sum = coin_sum + ACC_W'(COIN_VALUES[i*MONEY_W +: MONEY_W]);
  end

  assign pay_sum = ACC_W'(input_money) + coin_sum;
  // An overflowing pulse is refused as a whole, so the total stays put.
  assign paid    = (pay_sum > MONEY_MAX) ? input_money : pay_sum[MONEY_W-1:0];

  // Values increase with index, so the last fitting coin is the largest.
  always_comb begin
    sel_val    = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++)
      if (COIN_VALUES[i*MONEY_W +: MONEY_W] <= change_money) begin
        sel_val    = COIN_VALUES[i*MONEY_W +: MONEY_W];
        sel_onehot = NUM_COINS'(1) << i;
      end
  end

  always_comb begin
    state_nxt    = state;
    need_nxt     = need_money;
    input_nxt    = input_money;
    change_nxt   = change_money;
    cart_nxt     = cart_count;
    coin_out_nxt = '0;
    reject_nxt   = 1'b0;
    done_nxt     = 1'b0;
    tmo_nxt      = '0;
    case (state)
      IDLE: if (sys_Confirm) state_nxt = SELECT;
      SELECT: begin
        tmo_nxt = activity ? '0 : tmo_cnt + TMO_W'(1);
        if (sys_Cancel || tmo_hit) begin
          need_nxt  = '0;
          cart_nxt  = '0;
          state_nxt = IDLE;
        end else if (sys_Goods || sys_Confirm) begin
          if (add_ok) begin
            cart_nxt = cart_count + CNT_W'(1);
            need_nxt = need_add;
          end
          if (sys_Confirm && (need_nxt != '0)) state_nxt = PAY;
        end
      end
      PAY: begin
        tmo_nxt    = activity ? '0 : tmo_cnt + TMO_W'(1);
        reject_nxt = (|coin_in) && (pay_sum > MONEY_MAX);
        input_nxt  = paid;
        if (sys_Cancel) begin
          state_nxt  = REFUND;
          change_nxt = paid;
        end else if (sys_Change && (paid >= need_money)) begin
          state_nxt  = CHANGE;
          change_nxt = paid - need_money;
        end else if (tmo_hit) begin
          state_nxt  = REFUND;
          change_nxt = input_money;
        end
      end
      CHANGE, REFUND: begin
        reject_nxt = |coin_in;
        if (change_money != '0) begin
          coin_out_nxt = sel_onehot;
          change_nxt   = change_money - sel_val;
        end
        if (change_nxt == '0) begin
          state_nxt = (state == CHANGE) ? DONE : IDLE;
          done_nxt  = (state == CHANGE);
          input_nxt = '0;
          need_nxt  = '0;
          cart_nxt  = '0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) tmo_nxt = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      need_money   <= '0;
      input_money  <= '0;
      change_money <= '0;
      cart_count   <= '0;
      cart_full    <= 1'b0;
      coin_out     <= '0;
      coin_reject  <= 1'b0;
      vend_done    <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      need_money   <= need_nxt;
      input_money  <= input_nxt;
      change_money <= change_nxt;
      cart_count   <= cart_nxt;
      cart_full    <= (cart_nxt == CNT_W'(CART_DEPTH));
      coin_out     <= coin_out_nxt;
      coin_reject  <= reject_nxt;
      vend_done    <= done_nxt;
      tmo_cnt      <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: price ROM = high*10+low, timeout shortened to 20.
module tb_vend_ctrl_param;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       sys_Goods, sys_Confirm, sys_Change, sys_Cancel;
  logic [4:0] coin_in;
  logic [2:0] type_SW_high, type_SW_low;
  logic [1:0] num_SW;
  logic [5:0] price_addr;
  logic [7:0] price_data;
  logic [7:0] need_money, input_money, change_money;
  logic [4:0] coin_out;
  logic       coin_reject;
  logic [2:0] cart_count;
  logic       cart_full, vend_done;
  logic [5:0] state_out;

  int checks   = 0;
  int failures = 0;
  int tmo_n;
  bit found;

  always #5 sys_clk = ~sys_clk;

  always_comb price_data = 8'(price_addr[5:3]) * 8'd10 + 8'(price_addr[2:0]);

  vend_ctrl_param #(.TIMEOUT_CYC(20)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm),
    .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
    .coin_in(coin_in), .type_SW_high(type_SW_high), .type_SW_low(type_SW_low),
    .num_SW(num_SW), .price_addr(price_addr), .price_data(price_data),
    .need_money(need_money), .input_money(input_money), .change_money(change_money),
    .coin_out(coin_out), .coin_reject(coin_reject), .cart_count(cart_count),
    .cart_full(cart_full), .vend_done(vend_done), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    sys_Goods = 0; sys_Confirm = 0; sys_Change = 0; sys_Cancel = 0; coin_in = '0;
  endtask

  task automatic coin(input logic [4:0] c);
    coin_in = c; tick(); coin_in = '0;
  endtask

  initial begin
    sys_rst_n = 0;
    clear_inputs();
    type_SW_high = 0; type_SW_low = 0; num_SW = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_state", state_out, 6'b000001);
    chk("rst_need", need_money, 0);
    chk("rst_input", input_money, 0);
    chk("rst_change", change_money, 0);
    chk("rst_cart", cart_count, 0);
    chk("rst_coin_out", coin_out, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_done", vend_done, 0);
    sys_rst_n = 1;

    // Main purchase with change
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    chk("sel_state", state_out, 6'b000010);
    chk("sel_need", need_money, 0);
    chk("sel_cart", cart_count, 0);
    type_SW_high = 2; type_SW_low = 1; num_SW = 3;
    sys_Goods = 1; tick(); sys_Goods = 0;
    chk("goods_need", need_money, 63);
    chk("goods_cart", cart_count, 1);
    type_SW_high = 3; type_SW_low = 3; num_SW = 1;
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    chk("conf_need", need_money, 96);
    chk("conf_cart", cart_count, 2);
    chk("conf_state", state_out, 6'b000100);
    for (int i = 0; i < 5; i++) coin(5'(1 << i));
    chk("coins_86", input_money, 86);
    chk("coins_noreject", coin_reject, 0);
    sys_Change = 1; tick(); sys_Change = 0;
    chk("short_change_state", state_out, 6'b000100);
    coin(5'b10000);
    chk("coins_136", input_money, 136);
    sys_Change = 1; tick(); sys_Change = 0;
    chk("chg_state", state_out, 6'b001000);
    chk("chg_amount", change_money, 40);
    tick();
    chk("chg_coin1", coin_out, 5'b01000);
    chk("chg_left1", change_money, 20);
    tick();
    chk("chg_coin2", coin_out, 5'b01000);
    chk("chg_left2", change_money, 0);
    chk("done_state", state_out, 6'b100000);
    chk("done_pulse", vend_done, 1);
    chk("done_input", input_money, 0);
    chk("done_cart", cart_count, 0);
    tick();
    chk("post_done_state", state_out, 6'b000001);
    chk("post_done_pulse", vend_done, 0);
    chk("post_done_coin", coin_out, 0);

    // Refund of 27 with a rejected coin during dispensing
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    type_SW_high = 0; type_SW_low = 1; num_SW = 1;
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    chk("ref_need", need_money, 1);
    coin(5'b01000); coin(5'b00011); coin(5'b00001);
    chk("ref_input", input_money, 27);
    sys_Cancel = 1; tick(); sys_Cancel = 0;
    chk("ref_state", state_out, 6'b010000);
    chk("ref_amount", change_money, 27);
    coin(5'b00001);
    chk("ref_coin1", coin_out, 5'b01000);
    chk("ref_reject", coin_reject, 1);
    chk("ref_input_hold", input_money, 27);
    tick();
    chk("ref_coin2", coin_out, 5'b00010);
    tick();
    chk("ref_coin3", coin_out, 5'b00001);
    tick();
    chk("ref_coin4", coin_out, 5'b00001);
    chk("ref_idle", state_out, 6'b000001);
    chk("ref_input_clr", input_money, 0);
    chk("ref_need_clr", need_money, 0);
    chk("ref_change_clr", change_money, 0);

    // Overflow rejection, multi-coin pulses, reset mid-dispense
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    coin(5'b11111);
    chk("multi_86", input_money, 86);
    coin(5'b11111); coin(5'b10000); coin(5'b01000); coin(5'b00001); coin(5'b00001);
    coin(5'b00011);
    chk("sum_1_5", input_money, 250);
    coin(5'b00100);
    chk("ovf_reject", coin_reject, 1);
    chk("ovf_hold", input_money, 250);
    tick();
    chk("ovf_reject_end", coin_reject, 0);
    sys_Cancel = 1; tick(); sys_Cancel = 0;
    tick();
    chk("big_coin", coin_out, 5'b10000);
    chk("big_left", change_money, 200);
    #2 sys_rst_n = 0;
    #1;
    chk("mid_rst_state", state_out, 6'b000001);
    chk("mid_rst_coin", coin_out, 0);
    chk("mid_rst_change", change_money, 0);
    chk("mid_rst_input", input_money, 0);
    sys_rst_n = 1;

    // Cancel in SELECT
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    type_SW_high = 2; type_SW_low = 1; num_SW = 3;
    sys_Goods = 1; tick(); sys_Goods = 0;
    chk("sc_need", need_money, 63);
    sys_Cancel = 1; tick(); sys_Cancel = 0;
    chk("sc_state", state_out, 6'b000001);
    chk("sc_need_clr", need_money, 0);
    chk("sc_cart_clr", cart_count, 0);

    // Empty confirm, full cart, PAY timeout
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    num_SW = 0;
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    chk("empty_conf_state", state_out, 6'b000010);
    type_SW_high = 0; type_SW_low = 1; num_SW = 1;
    repeat (4) begin sys_Goods = 1; tick(); sys_Goods = 0; end
    chk("full_cart", cart_count, 4);
    chk("full_flag", cart_full, 1);
    chk("full_need", need_money, 4);
    sys_Goods = 1; tick(); sys_Goods = 0;
    chk("over_cart", cart_count, 4);
    chk("over_need", need_money, 4);
    sys_Confirm = 1; tick(); sys_Confirm = 0;
    chk("full_pay", state_out, 6'b000100);
    tmo_n = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      if (state_out == 6'b010000) begin found = 1; tmo_n = k; end
    end
    chk("timeout_cycles", tmo_n, 20);
    tick();
    chk("tmo_idle", state_out, 6'b000001);
    chk("tmo_cart_clr", cart_count, 0);
    chk("tmo_full_clr", cart_full, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
